ps2_rx_fifo: RTL



---
 rtl/ps2_rx_fifo.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised and glitch-filtered inputs, an 11-bit
// frame decoder with parity/stop/timeout checking, and a show-ahead byte FIFO.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 100000,
    parameter int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             ck,
    input  logic             reset,
    input  logic             scl,
    input  logic             sda,
    output logic [7:0]       data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overflow,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state, next_state;

    logic [1:0]    raw_lines;
    logic [1:0]    sync1, sync2, filt;
    logic [FW-1:0] fcnt [2];
    logic          scl_d;
    logic          fall, scl_edge, sda_f;

    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          pbit;
    logic [TW-1:0] tcnt;
    logic          timeout;

    logic          shift_en, latch_parity, clear_bits;
    logic          push_req, perr_req, ferr_req;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          fifo_full, pop, push_ok;

    // Bit 0 is scl, bit 1 is sda; a line only moves after FILTER_LEN agreeing samples.
    assign raw_lines = {sda, scl};

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
            filt  <= 2'b11;
            scl_d <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                fcnt[i] <= '0;
            end
        end else begin
            sync1 <= raw_lines;
            sync2 <= sync1;
            scl_d <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign fall     = scl_d & ~filt[0];
    assign scl_edge = scl_d ^ filt[0];
    assign sda_f    = filt[1];
    assign timeout  = (state != IDLE) && !scl_edge && (tcnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (timeout) begin
            next_state = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!sda_f) next_state = DATA;
                DATA:    if (bit_cnt == 3'd7) next_state = PARITY;
                PARITY:  next_state = STOP;
                STOP:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // The stop bit is judged before parity so a frame raises at most one error.
    always_comb begin
        shift_en     = 1'b0;
        latch_parity = 1'b0;
        clear_bits   = 1'b0;
        push_req     = 1'b0;
        perr_req     = 1'b0;
        ferr_req     = timeout;
        if (fall && !timeout) begin
            case (state)
                IDLE:   clear_bits = 1'b1;
                DATA:   shift_en = 1'b1;
                PARITY: latch_parity = 1'b1;
                STOP: begin
                    if (!sda_f) begin
                        ferr_req = 1'b1;
                    end else if (^{shreg, pbit} == 1'b0) begin
                        perr_req = 1'b1;
                    end else begin
                        push_req = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
            shreg   <= '0;
            pbit    <= 1'b0;
            tcnt    <= '0;
        end else begin
            if (clear_bits) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                shreg[bit_cnt] <= sda_f;
                bit_cnt        <= bit_cnt + 1'b1;
            end
            if (latch_parity) begin
                pbit <= sda_f;
            end
            if (state == IDLE || scl_edge) begin
                tcnt <= '0;
            end else if (!timeout) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign data_valid = (fifo_count != '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign pop        = data_valid & data_ready;
    assign push_ok    = push_req & (~fifo_full | pop);
    assign data_out   = data_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge ck) begin
        if (push_ok) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            parity_err <= perr_req;
            frame_err  <= ferr_req;
            overflow   <= push_req & fifo_full & ~pop;
        end
    end

endmodule
